// File: rtl/mini16_s2m_collector.sv
// mini16_s2m_collector: round-robin drain of PE slave-to-master FIFOs onto one master write port
module mini16_s2m_collector #(
  parameter int NUM_PE = 4,
  parameter int WIDTH_D = 16,
  parameter int DEPTH_V_F = 16,
  parameter int READ_LATENCY = 2,
  parameter int SKID_DEPTH = 4,
  parameter int BURST_MAX = 8,
  parameter int MISS_LIMIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic [NUM_PE-1:0] fifo_req_r,
  input  logic [NUM_PE-1:0] fifo_valid,
  input  logic [NUM_PE*(WIDTH_D+DEPTH_V_F)-1:0] fifo_r_data,
  output logic out_we,
  input  logic out_ready,
  output logic [DEPTH_V_F-1:0] out_addr,
  output logic [WIDTH_D-1:0] out_data,
  output logic [$clog2(NUM_PE)-1:0] out_src,
  output logic [15:0] word_count,
  output logic busy
);
  localparam int SW = $clog2(NUM_PE);
  localparam int W = WIDTH_D + DEPTH_V_F;
  localparam int AW = $clog2(SKID_DEPTH);
  localparam int CW = $clog2(SKID_DEPTH) + 2;
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_DRAIN = 2'd1, S_FLUSH = 2'd2;
  logic [1:0] state;
  logic [SW-1:0] grant;
  logic [READ_LATENCY:0] pipe;
  logic [BW-1:0] burst_cnt;
  logic [MW-1:0] miss_cnt;
  logic [SW+W-1:0] mem [SKID_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fcnt, outst, occ;
  logic matured, hit, pop, free_out, from_fifo, direct, push, leave, room, req;
  logic [W-1:0] word;
  logic [SW+W-1:0] entry;
  always_comb begin
    outst = '0;
    for (int i = 0; i <= READ_LATENCY; i++) outst = outst + CW'(pipe[i]);
  end
  assign matured = pipe[READ_LATENCY];
  assign hit = matured && fifo_valid[grant];
  assign word = fifo_r_data[grant*W +: W];
  assign pop = out_we && out_ready;
  assign free_out = !out_we || out_ready;
  // A response may bypass the skid FIFO straight into the output register when nothing is queued ahead
  assign from_fifo = fcnt != '0 && free_out;
  assign direct = hit && fcnt == '0 && free_out;
  assign push = hit && !direct;
  assign entry = from_fifo ? mem[rd_ptr] : {grant, word};
  // Occupancy counts the output register; slots are reserved for every request still in flight
  assign occ = fcnt + CW'(out_we);
  assign room = occ + outst - CW'(pop) < CW'(SKID_DEPTH);
  assign leave = !enable || burst_cnt == BW'(BURST_MAX) || miss_cnt == MW'(MISS_LIMIT);
  assign req = state == S_DRAIN && !leave && room;
  assign busy = state != S_IDLE || occ != '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {grant, word};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      grant <= '0;
      pipe <= '0;
      burst_cnt <= '0;
      miss_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt <= '0;
      fifo_req_r <= '0;
      out_we <= 1'b0;
      out_src <= '0;
      out_addr <= '0;
      out_data <= '0;
      word_count <= '0;
    end else begin
      pipe <= {pipe[READ_LATENCY-1:0], req};
      fifo_req_r <= req ? NUM_PE'(1) << grant : '0;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(from_fifo);
      fcnt <= fcnt + CW'(push) - CW'(from_fifo);
      out_we <= from_fifo || direct || (out_we && !out_ready);
      if (from_fifo || direct) {out_src, out_addr, out_data} <= entry;
      word_count <= word_count + 16'(pop);
      if (req) burst_cnt <= burst_cnt + 1'b1;
      if (matured) miss_cnt <= fifo_valid[grant] ? '0 : miss_cnt + MW'(miss_cnt != MW'(MISS_LIMIT));
      if (state == S_IDLE && enable) begin
        state <= S_DRAIN;
        burst_cnt <= '0;
        miss_cnt <= '0;
      end
      if (state == S_DRAIN && leave) state <= S_FLUSH;
      if (state == S_FLUSH && outst == '0) begin
        state <= enable ? S_DRAIN : S_IDLE;
        grant <= grant == SW'(NUM_PE - 1) ? '0 : grant + 1'b1;
        burst_cnt <= '0;
        miss_cnt <= '0;
      end
    end
  end
endmodule
